// File: rtl/bola.sv
// bola: ball controller for the brick-breaker game.
// Holds the ball on the ship until launched, moves it on a fixed tick,
// reflects it off the walls and the ship, pulses bateu on each ship hit and
// perdeu when the ball drops past the bottom edge.
// Optional feature macro: BOLA_ACELERA_EN (each ship hit raises the speed by
// one pixel per tick, saturating at 4).
module bola #(
  parameter int TICK_DIV  = 833333,
  parameter int BALL_SIZE = 8,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int STEP      = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetNave,
  input  logic       pausa,
  input  logic       iniciarBola,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] largura_nave,
  input  logic [9:0] altura_nave,
  output logic       bateu,
  output logic       perdeu,
  output logic [9:0] x_bola,
  output logic [9:0] y_bola,
  output logic [9:0] tamanho_bola,
  output logic       voando
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic signed [11:0] BS    = 12'(BALL_SIZE);
  localparam logic signed [11:0] XMAX  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] YLIM  = 12'(SCREEN_H);

  typedef enum logic [1:0] {PARADA, VOANDO, PERDIDA} estado_t;

  estado_t estado, estado_prox;

  logic [CNT_W-1:0] contador;
  logic             tick, lancar;
  logic [2:0]       velocidade;
  logic             dx_neg, dy_neg, dx_neg_prox, dy_neg_prox;
  logic [9:0]       x_preso, y_preso, x_prox, y_prox;
  logic signed [11:0] vel, dx, dy, xb, yb, nx, ny, xn, yn, wn, hn;
  logic             acerto, fundo;

  assign tamanho_bola = 10'(BALL_SIZE);
  assign x_preso      = x_nave + (largura_nave >> 1) - 10'(BALL_SIZE / 2);
  assign y_preso      = y_nave - 10'(BALL_SIZE);
  assign lancar       = (estado == PARADA) && iniciarBola && !pausa;
  assign tick         = (estado == VOANDO) && !pausa && (contador == CNT_MAX);

`ifdef BOLA_ACELERA_EN
  // Speed grows by one on every ship hit, saturating at 4; a lost ball restarts slow
  always_ff @(posedge CLOCK_50 or posedge resetNave) begin
    if (resetNave)
      velocidade <= 3'(STEP);
    else if (estado == PERDIDA)
      velocidade <= 3'(STEP);
    else if (tick && acerto && velocidade < 3'd4)
      velocidade <= velocidade + 3'd1;
  end
`else
  assign velocidade = 3'(STEP);
`endif

  // Signed next-position arithmetic and the ship-hit / bottom-edge tests
  always_comb begin
    xb     = signed'({2'b00, x_bola});
    yb     = signed'({2'b00, y_bola});
    xn     = signed'({2'b00, x_nave});
    yn     = signed'({2'b00, y_nave});
    wn     = signed'({2'b00, largura_nave});
    hn     = signed'({2'b00, altura_nave});
    vel    = signed'({9'd0, velocidade});
    dx     = dx_neg ? -vel : vel;
    dy     = dy_neg ? -vel : vel;
    nx     = xb + dx;
    ny     = yb + dy;
    acerto = !dy_neg && (yb + BS + dy >= yn) && (yb + BS <= yn + hn) &&
             (xb + BS > xn) && (xb < xn + wn);
    fundo  = (ny + BS >= YLIM);
  end

  // Wall reflection: x and y clamp independently so corners bounce both ways
  always_comb begin
    x_prox      = nx[9:0];
    dx_neg_prox = dx_neg;
    y_prox      = ny[9:0];
    dy_neg_prox = dy_neg;
    if (nx < 0) begin
      x_prox      = 10'd0;
      dx_neg_prox = 1'b0;
    end else if (nx > XMAX) begin
      x_prox      = XMAX[9:0];
      dx_neg_prox = 1'b1;
    end
    if (ny < 0) begin
      y_prox      = 10'd0;
      dy_neg_prox = 1'b0;
    end
  end

  // State register
  always_ff @(posedge CLOCK_50 or posedge resetNave) begin
    if (resetNave) estado <= PARADA;
    else           estado <= estado_prox;
  end

  // Next-state logic: launch, lose the ball on the bottom edge, reattach
  always_comb begin
    estado_prox = estado;
    unique case (estado)
      PARADA:  if (lancar) estado_prox = VOANDO;
      VOANDO:  if (tick && !acerto && fundo) estado_prox = PERDIDA;
      PERDIDA: estado_prox = PARADA;
      default: estado_prox = PARADA;
    endcase
  end

  // State-decoded output
  always_comb begin
    voando = (estado == VOANDO);
  end

  // Ball position, direction, tick counter and the one-cycle event pulses
  always_ff @(posedge CLOCK_50 or posedge resetNave) begin
    if (resetNave) begin
      x_bola   <= 10'd0;
      y_bola   <= 10'd0;
      bateu    <= 1'b0;
      perdeu   <= 1'b0;
      dx_neg   <= 1'b0;
      dy_neg   <= 1'b1;
      contador <= '0;
    end else begin
      bateu  <= 1'b0;
      perdeu <= 1'b0;
      unique case (estado)
        PARADA: begin
          x_bola   <= x_preso;
          y_bola   <= y_preso;
          contador <= '0;
          if (lancar) begin
            dx_neg <= 1'b0;
            dy_neg <= 1'b1;
          end
        end
        VOANDO: begin
          if (!pausa)
            contador <= tick ? '0 : contador + CNT_W'(1);
          if (tick) begin
            if (acerto) begin
              bateu  <= 1'b1;
              x_bola <= x_prox;
              dx_neg <= dx_neg_prox;
              y_bola <= y_preso;
              dy_neg <= 1'b1;
            end else if (fundo) begin
              perdeu <= 1'b1;
            end else begin
              x_bola <= x_prox;
              dx_neg <= dx_neg_prox;
              y_bola <= y_prox;
              dy_neg <= dy_neg_prox;
            end
          end
        end
        PERDIDA: begin
          x_bola   <= x_preso;
          y_bola   <= y_preso;
          contador <= '0;
        end
        default: begin
          contador <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bola.sv
// tb_bola: randomized self-checking bench for bola against a behavioural
// model of the ball rules, plus fixed-value checks of the key scenarios.
module tb_bola;

  localparam int TICK_DIV = 4;
  localparam int BALL     = 8;
  localparam int SW       = 640;
  localparam int SH       = 480;
  localparam int STEP     = 2;
  localparam int SPD_MAX  = 4;

  localparam int M_PARKED = 0;
  localparam int M_FLYING = 1;
  localparam int M_LOST   = 2;

  logic       CLOCK_50 = 1'b0;
  logic       resetNave;
  logic       pausa;
  logic       iniciarBola;
  logic [9:0] x_nave, y_nave, largura_nave, altura_nave;
  logic       bateu, perdeu, voando;
  logic [9:0] x_bola, y_bola, tamanho_bola;

  int vectors = 0;
  int miscompares = 0;

  int  m_state, mx, my, mvx, mvy, mspd, mphase;
  bit  mbateu, mperdeu;

  bola #(
    .TICK_DIV (TICK_DIV),
    .BALL_SIZE(BALL),
    .SCREEN_W (SW),
    .SCREEN_H (SH),
    .STEP     (STEP)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetNave   (resetNave),
    .pausa       (pausa),
    .iniciarBola (iniciarBola),
    .x_nave      (x_nave),
    .y_nave      (y_nave),
    .largura_nave(largura_nave),
    .altura_nave (altura_nave),
    .bateu       (bateu),
    .perdeu      (perdeu),
    .x_bola      (x_bola),
    .y_bola      (y_bola),
    .tamanho_bola(tamanho_bola),
    .voando      (voando)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic ini, input logic [9:0] xn);
    pausa       = p;
    iniciarBola = ini;
    x_nave      = xn;
  endtask

  function automatic int attachX();
    return (int'(x_nave) + int'(largura_nave) / 2 - BALL / 2) & 1023;
  endfunction

  function automatic int attachY();
    return (int'(y_nave) - BALL) & 1023;
  endfunction

  task automatic modelReset();
    m_state = M_PARKED;
    mx = 0; my = 0;
    mspd = STEP; mvx = STEP; mvy = -STEP;
    mphase = 0;
    mbateu = 0; mperdeu = 0;
  endtask

  task automatic wallX(input int nx);
    if (nx < 0) begin
      mx = 0; mvx = mspd;
    end else if (nx > SW - BALL) begin
      mx = SW - BALL; mvx = -mspd;
    end else begin
      mx = nx;
    end
  endtask

  task automatic modelMove();
    int nx, ny, xn, yn, wn, hn;
    bit hit;
    xn = int'(x_nave); yn = int'(y_nave);
    wn = int'(largura_nave); hn = int'(altura_nave);
    nx = mx + mvx;
    ny = my + mvy;
    hit = (mvy > 0) && (my + BALL + mvy >= yn) && (my + BALL <= yn + hn) &&
          (mx + BALL > xn) && (mx < xn + wn);
    if (hit) begin
`ifdef BOLA_ACELERA_EN
      if (mspd < SPD_MAX) mspd++;
`endif
      mbateu = 1;
      my  = yn - BALL;
      mvy = -mspd;
      mvx = (mvx < 0) ? -mspd : mspd;
      wallX(nx);
    end else if (ny + BALL >= SH) begin
      m_state = M_LOST;
      mperdeu = 1;
    end else begin
      wallX(nx);
      if (ny < 0) begin
        my = 0; mvy = mspd;
      end else begin
        my = ny;
      end
    end
  endtask

  task automatic modelEdge();
    mbateu = 0; mperdeu = 0;
    case (m_state)
      M_PARKED: begin
        mx = attachX(); my = attachY();
        if (iniciarBola && !pausa) begin
          m_state = M_FLYING;
          mvx = mspd; mvy = -mspd;
          mphase = 0;
        end
      end
      M_FLYING: begin
        if (!pausa) begin
          mphase++;
          if (mphase == TICK_DIV) begin
            mphase = 0;
            modelMove();
          end
        end
      end
      default: begin
        m_state = M_PARKED;
        mspd = STEP;
        mx = attachX(); my = attachY();
      end
    endcase
  endtask

  task automatic runCycle();
    @(posedge CLOCK_50);
    modelEdge();
    @(negedge CLOCK_50);
    checkOutput("x_bola", x_bola, mx);
    checkOutput("y_bola", y_bola, my);
    checkOutput("bateu", bateu, mbateu);
    checkOutput("perdeu", perdeu, mperdeu);
    checkOutput("voando", voando, (m_state == M_FLYING));
  endtask

  task automatic doReset();
    resetNave = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_x", x_bola, 0);
    checkOutput("rst_y", y_bola, 0);
    checkOutput("rst_voando", voando, 0);
    checkOutput("rst_bateu", bateu, 0);
    checkOutput("rst_perdeu", perdeu, 0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetNave = 1'b0;
  endtask

  int  wallExp [7] = '{623, 625, 627, 629, 631, 632, 630};
  bit  seen;
  int  savedX, savedY, shipX;
  bit  trackShip;
  logic [9:0] xnext;

  initial begin
    resetNave    = 1'b1;
    pausa        = 1'b0;
    iniciarBola  = 1'b0;
    x_nave       = 10'd350;
    y_nave       = 10'd420;
    largura_nave = 10'd30;
    altura_nave  = 10'd30;
    @(negedge CLOCK_50);
    doReset();
    checkOutput("tamanho_bola", tamanho_bola, BALL);

    // tracking right after reset
    runCycle();
    checkOutput("track_x", x_bola, 361);
    checkOutput("track_y", y_bola, 412);

    // launch and first two moves
    applyStimulus(1'b0, 1'b1, 10'd350);
    runCycle();
    checkOutput("launch_voando", voando, 1);
    applyStimulus(1'b0, 1'b0, 10'd350);
    repeat (TICK_DIV - 1) runCycle();
    checkOutput("hold_x", x_bola, 361);
    runCycle();
    checkOutput("tick1_x", x_bola, 363);
    checkOutput("tick1_y", y_bola, 410);
    repeat (TICK_DIV) runCycle();
    checkOutput("tick2_x", x_bola, 365);
    checkOutput("tick2_y", y_bola, 408);

    // fly up, bounce off the top, and steer the ship under the descending ball
    seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (mvy > 0 && my > 300) x_nave = 10'((mx >= 10) ? mx - 10 : 0);
      runCycle();
      if (bateu) seen = 1;
    end
    checkOutput("hit_seen", seen, 1);
    checkOutput("hit_y", y_bola, 412);
    runCycle();
    checkOutput("hit_pulse_end", bateu, 0);
    repeat (TICK_DIV - 1) runCycle();
`ifdef BOLA_ACELERA_EN
    checkOutput("after_hit_y", y_bola, 409);
`else
    checkOutput("after_hit_y", y_bola, 410);
`endif

    // miss: keep the ship far from the descending ball
    seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (mvy > 0) x_nave = (mx >= 320) ? 10'd0 : 10'd600;
      runCycle();
      if (perdeu) seen = 1;
    end
    checkOutput("miss_seen", seen, 1);
    shipX = int'(x_nave);
    runCycle();
    checkOutput("miss_pulse_end", perdeu, 0);
    checkOutput("miss_voando", voando, 0);
    checkOutput("miss_attach_x", x_bola, shipX + 11);
    checkOutput("miss_attach_y", y_bola, 412);

    // right wall
    applyStimulus(1'b0, 1'b0, 10'd610);
    doReset();
    runCycle();
    checkOutput("wall_start_x", x_bola, 621);
    applyStimulus(1'b0, 1'b1, 10'd610);
    runCycle();
    applyStimulus(1'b0, 1'b0, 10'd610);
    for (int i = 0; i < 7; i++) begin
      repeat (TICK_DIV) runCycle();
      checkOutput("wall_x", x_bola, wallExp[i]);
    end

    // pause mid-phase
    repeat (2) runCycle();
    savedX = int'(x_bola);
    savedY = int'(y_bola);
    applyStimulus(1'b1, 1'b0, 10'd610);
    repeat (20) runCycle();
    checkOutput("pause_x", x_bola, savedX);
    checkOutput("pause_y", y_bola, savedY);
    applyStimulus(1'b0, 1'b0, 10'd610);
    runCycle();
    checkOutput("resume_hold_x", x_bola, savedX);
    runCycle();
    checkOutput("resume_move_x", x_bola, savedX - STEP);

    // reset in mid-flight
    repeat (5) runCycle();
    doReset();

    // randomized play against the model
    trackShip = 1;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == M_PARKED) trackShip = ($urandom_range(0, 2) != 0);
      xnext = x_nave;
      if (m_state == M_FLYING && mvy > 0 && trackShip)
        xnext = 10'((mx >= 10) ? mx - 10 : 0);
      else if ($urandom_range(0, 15) == 0)
        xnext = 10'($urandom_range(0, 610));
      if ($urandom_range(0, 1499) == 0) begin
        doReset();
      end else begin
        applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0), xnext);
        runCycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no completion, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
